mmu_windowed: RTL and testbench

MMU_WINDOWED -- requirements
Module: mmu_windowed

---
 rtl/mmu_windowed.sv | 162 ++++++++++++++++
 tb/tb_mmu_windowed.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_windowed.sv
// mmu_windowed
//   Front end between a CPU request port and an external memory bus.
//   Addresses below SPEC_COUNT hit a small bank of special registers and are
//   served locally in one cycle; every other address is forwarded to the bus
//   as a single strobed read or write, with a bounded wait for memory_ready.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   execute, write                request strobe and direction (1 = write)
//   address, in_data              request address and write data
//   out_data                      read data (registered)
//   completed, error              one-cycle done pulse / timeout pulse
//   busy                          high while a bus cycle is outstanding
//   set_interrupt_return_address  load all special registers at once
//   interrupt_return_address      load value, MSB slice -> special reg 0
//   memory_address, memory_in     bus address / write data (registered)
//   memory_read_signal            bus read strobe (registered)
//   memory_write_signal           bus write strobe (registered)
//   memory_out, memory_ready      bus read data / acknowledge
//   pre_completed                 busy AND memory_ready (combinational)
module mmu_windowed #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int SPEC_COUNT = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         execute,
  input  logic                         write,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            in_data,
  output logic [DATA_W-1:0]            out_data,
  output logic                         completed,
  output logic                         error,
  output logic                         busy,
  input  logic                         set_interrupt_return_address,
  input  logic [SPEC_COUNT*DATA_W-1:0] interrupt_return_address,
  output logic [ADDR_W-1:0]            memory_address,
  output logic [DATA_W-1:0]            memory_in,
  output logic                         memory_read_signal,
  output logic                         memory_write_signal,
  input  logic [DATA_W-1:0]            memory_out,
  input  logic                         memory_ready,
  output logic                         pre_completed
);

  localparam int IDX_W = $clog2(SPEC_COUNT);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t            state;
  logic [7:0]        wait_cnt;
  logic [7:0]        wait_cnt_next;
  logic [DATA_W-1:0] spec [SPEC_COUNT];
  logic              win_hit;
  logic [IDX_W-1:0]  win_idx;
  logic              accept;

  assign win_hit       = (address < ADDR_W'(SPEC_COUNT));
  assign win_idx       = address[IDX_W-1:0];
  assign wait_cnt_next = wait_cnt + 8'd1;

  // A request is taken only in IDLE and never in the cycle completed is
  // high, which caps back-to-back window accesses at one per two cycles.
  assign accept        = (state == IDLE) && execute && !completed;

  assign busy          = (state == BUS);
  assign pre_completed = busy && memory_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      wait_cnt            <= '0;
      out_data            <= '0;
      completed           <= 1'b0;
      error               <= 1'b0;
      memory_address      <= '0;
      memory_in           <= '0;
      memory_read_signal  <= 1'b0;
      memory_write_signal <= 1'b0;
      for (int unsigned i = 0; i < SPEC_COUNT; i++) begin
        spec[i] <= '0;
      end
    end else begin
      completed <= 1'b0;
      error     <= 1'b0;

      // Bulk load happens in any state. A window read in the same cycle
      // still sees the old contents (non-blocking update).
      if (set_interrupt_return_address) begin
        for (int unsigned i = 0; i < SPEC_COUNT; i++) begin
          spec[i] <= interrupt_return_address[(SPEC_COUNT-1-i)*DATA_W +: DATA_W];
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (win_hit) begin
              completed <= 1'b1;
              if (write) begin
                // Bulk load wins over a colliding window write.
                if (!set_interrupt_return_address) begin
                  spec[win_idx] <= in_data;
                end
              end else begin
                out_data <= spec[win_idx];
              end
            end else begin
              memory_address      <= address;
              if (write) begin
                memory_in <= in_data;
              end
              memory_read_signal  <= !write;
              memory_write_signal <= write;
              wait_cnt            <= '0;
              state               <= BUS;
            end
          end
        end

        BUS: begin
          if (memory_ready) begin
            // Acknowledge wins even on the cycle the timeout would fire.
            if (memory_read_signal) begin
              out_data <= memory_out;
            end
            memory_read_signal  <= 1'b0;
            memory_write_signal <= 1'b0;
            completed           <= 1'b1;
            state               <= IDLE;
          end else begin
            wait_cnt <= wait_cnt_next;
            if (wait_cnt_next == 8'(TIMEOUT)) begin
              memory_read_signal  <= 1'b0;
              memory_write_signal <= 1'b0;
              completed           <= 1'b1;
              error               <= 1'b1;
              state               <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Structural invariants of the bus interface.
  a_one_strobe: assert property (@(posedge clk)
    !(memory_read_signal && memory_write_signal));
  a_idle_quiet: assert property (@(posedge clk)
    (state == IDLE) |-> (!memory_read_signal && !memory_write_signal));
  a_busy_strobe: assert property (@(posedge clk)
    (state == BUS) |-> (memory_read_signal || memory_write_signal));
  a_err_done: assert property (@(posedge clk) error |-> completed);

endmodule

// File: tb/tb_mmu_windowed.sv
// Directed bench for mmu_windowed (TIMEOUT = 4). Expected completions are
// queued by the stimulus process; a monitor pops one per completed pulse.
module tb_mmu_windowed;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int SPEC_COUNT = 2;
  localparam int TIMEOUT = 4;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         execute;
  logic                         write;
  logic [ADDR_W-1:0]            address;
  logic [DATA_W-1:0]            in_data;
  logic [DATA_W-1:0]            out_data;
  logic                         completed;
  logic                         error;
  logic                         busy;
  logic                         set_irq;
  logic [SPEC_COUNT*DATA_W-1:0] irq_val;
  logic [ADDR_W-1:0]            memory_address;
  logic [DATA_W-1:0]            memory_in;
  logic                         memory_read_signal;
  logic                         memory_write_signal;
  logic [DATA_W-1:0]            memory_out;
  logic                         memory_ready;
  logic                         pre_completed;

  mmu_windowed #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .SPEC_COUNT(SPEC_COUNT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .execute(execute),
    .write(write),
    .address(address),
    .in_data(in_data),
    .out_data(out_data),
    .completed(completed),
    .error(error),
    .busy(busy),
    .set_interrupt_return_address(set_irq),
    .interrupt_return_address(irq_val),
    .memory_address(memory_address),
    .memory_in(memory_in),
    .memory_read_signal(memory_read_signal),
    .memory_write_signal(memory_write_signal),
    .memory_out(memory_out),
    .memory_ready(memory_ready),
    .pre_completed(pre_completed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
    string             tag;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every completed pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && completed) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completed", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, "_data"}, 32'(out_data), 32'(e.data));
        chk({e.tag, "_err"},  32'(error),    32'(e.err));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input logic [DATA_W-1:0] d, input logic e, input string tag);
    exp_t x;
    x.data = d; x.err = e; x.tag = tag;
    exp_q.push_back(x);
  endtask

  // Drives one request for a single edge; returns #1 after that edge.
  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    execute = 1'b1; write = w; address = a; in_data = d;
    tick();
    execute = 1'b0;
  endtask

  initial begin
    reset = 1'b1; execute = 1'b0; write = 1'b0; address = '0; in_data = '0;
    set_irq = 1'b0; irq_val = '0; memory_out = '0; memory_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_flags", {completed, error, busy, memory_read_signal, memory_write_signal}, 32'h0);
    chk("rst_bus", {memory_address, memory_in}, 32'h0);

    // memory_ready in IDLE is ignored
    tick();
    memory_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready_precomp", 32'(pre_completed), 32'h0);
    tick();
    memory_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready_busy", {busy, completed}, 32'h0);

    // Window load and reads
    tick();
    irq_val = 16'hABCD; set_irq = 1'b1;
    tick();
    set_irq = 1'b0;
    expect_done(8'hAB, 1'b0, "win_rd0");
    issue(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("win_rd0_latency", 32'(completed), 32'h1);
    chk("win_rd0_nostrobe", {memory_read_signal, memory_write_signal, busy}, 32'h0);
    tick();
    expect_done(8'hCD, 1'b0, "win_rd1");
    issue(1'b0, 8'h01, 8'h00);
    @(negedge clk);
    chk("win_rd1_latency", 32'(completed), 32'h1);
    // execute during the completed cycle is dropped
    issue(1'b0, 8'h40, 8'h00);
    @(negedge clk);
    chk("exec_in_done_ignored", {memory_read_signal, busy, completed}, 32'h0);

    // Bus read, ready in 4th strobe cycle (also the timeout boundary)
    tick();
    expect_done(8'h5A, 1'b0, "bus_rd");
    issue(1'b0, 8'h40, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        memory_ready = 1'b1; memory_out = 8'h5A;
      end
      @(negedge clk);
      chk($sformatf("bus_rd_strobe_c%0d", c), {memory_read_signal, memory_write_signal, busy}, 32'b101);
      chk($sformatf("bus_rd_precomp_c%0d", c), 32'(pre_completed), (c == 4) ? 32'h1 : 32'h0);
      if (c == 1) chk("bus_rd_addr", 32'(memory_address), 32'h40);
      tick();
    end
    memory_ready = 1'b0; memory_out = 8'h00;
    @(negedge clk);
    chk("bus_rd_end", {memory_read_signal, busy, completed}, 32'b001);

    // Bus write, ready in 2nd strobe cycle; out_data unchanged
    tick();
    expect_done(8'h5A, 1'b0, "bus_wr");
    issue(1'b1, 8'h10, 8'h77);
    @(negedge clk);
    chk("bus_wr_c1", {memory_write_signal, memory_read_signal}, 32'b10);
    chk("bus_wr_data", {memory_address, memory_in}, 32'h1077);
    tick();
    memory_ready = 1'b1;
    @(negedge clk);
    chk("bus_wr_c2", {memory_write_signal, memory_read_signal}, 32'b10);
    tick();
    memory_ready = 1'b0;
    @(negedge clk);
    chk("bus_wr_end", {memory_write_signal, memory_read_signal, busy}, 32'h0);

    // Timeout
    tick();
    expect_done(8'h5A, 1'b1, "timeout");
    issue(1'b0, 8'h20, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("to_strobe_c%0d", c), {memory_read_signal, completed}, 32'b10);
      tick();
    end
    @(negedge clk);
    chk("to_drop", {memory_read_signal, busy, completed, error}, 32'b0011);
    tick();
    @(negedge clk);
    chk("to_pulse_once", {completed, error}, 32'h0);

    // Load vs. window write collision
    tick();
    irq_val = 16'hBEEF; set_irq = 1'b1;
    expect_done(8'h5A, 1'b0, "coll_wr");
    issue(1'b1, 8'h01, 8'h11);
    set_irq = 1'b0;
    tick();
    expect_done(8'hEF, 1'b0, "coll_rd1");
    issue(1'b0, 8'h01, 8'h00);
    tick();
    // Same-cycle load and read: read returns pre-load value
    irq_val = 16'h1234; set_irq = 1'b1;
    expect_done(8'hBE, 1'b0, "load_rd_old");
    issue(1'b0, 8'h00, 8'h00);
    set_irq = 1'b0;
    tick();
    expect_done(8'h12, 1'b0, "load_rd_new");
    issue(1'b0, 8'h00, 8'h00);
    tick();

    // Reset mid-BUS
    issue(1'b0, 8'h40, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_bus_drop", {memory_read_signal, busy, completed}, 32'h0);
    tick();
    expect_done(8'h00, 1'b0, "post_rst_rd");
    issue(1'b0, 8'h00, 8'h00);
    tick(); tick();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
